// File: rtl/mskrnd_lfsr_feed_if.sv
// rtl/mskrnd_lfsr_feed_if.sv - seed and randomness stream bundle for mskrnd_lfsr_feed
// master is the randomness feed itself; slave is the seed source plus gadget-array consumer.
interface mskrnd_lfsr_feed_if #(
    parameter int RND_W = 64
);
    logic [63:0]      seed_in;
    logic             seed_valid;
    logic             seed_ready;
    logic             reseed;
    logic [RND_W-1:0] out_rnd;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        input  seed_in, seed_valid, reseed, out_ready,
        output seed_ready, out_rnd, out_valid, busy
    );

    modport slave (
        output seed_in, seed_valid, reseed, out_ready,
        input  seed_ready, out_rnd, out_valid, busy
    );
endinterface

// File: rtl/mskrnd_lfsr_feed.sv
// rtl/mskrnd_lfsr_feed.sv - K-lane 64-bit Galois LFSR randomness feed for HPC3 gadgets
// Optional seed zero guard: define MSKRND_ZERO_GUARD_EN.
module mskrnd_lfsr_feed #(
    parameter int d         = 2,
    parameter int N_GADGETS = 32,
    parameter int WARMUP    = 4
) (
    input  logic                clk,
    input  logic                syn_rst,
    mskrnd_lfsr_feed_if.master  bus
);
    localparam int HPC3RND = d * (d - 1);
    localparam int RND_W   = N_GADGETS * HPC3RND;
    localparam int K       = (RND_W + 63) / 64;
    localparam int WC_W    = (K > 1) ? $clog2(K) : 1;
    localparam logic [63:0] POLY = 64'hD800000000000000;

    typedef enum logic [1:0] {
        ST_SEED = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WC_W-1:0]   wc, wc_nxt;
    logic [7:0]        wcnt, wcnt_nxt;
    logic [K*64-1:0]   lanes, lanes_nxt;
    logic [63:0]       seed_word;
    logic              do_adv;

    // 64 chained single steps flatten into one combinational leap per cycle
    function automatic logic [63:0] lfsr_adv(input logic [63:0] s);
        logic [63:0] v;
        v = s;
        for (int i = 0; i < 64; i++) begin
            v = (v >> 1) ^ (v[0] ? POLY : 64'd0);
        end
        return v;
    endfunction

    always_comb begin
`ifdef MSKRND_ZERO_GUARD_EN
        seed_word = (bus.seed_in == 64'd0) ? 64'd1 : bus.seed_in;
`else
        seed_word = bus.seed_in;
`endif
    end

    always_comb begin
        state_nxt = state;
        wc_nxt    = wc;
        wcnt_nxt  = wcnt;
        lanes_nxt = lanes;
        do_adv    = 1'b0;

        case (state)
            ST_SEED: begin
                if (bus.seed_valid && !bus.reseed) begin
                    for (int k = 0; k < K; k++) begin
                        if (wc == WC_W'(k)) lanes_nxt[k*64 +: 64] = seed_word;
                    end
                    if (wc == WC_W'(K - 1)) begin
                        wc_nxt   = '0;
                        wcnt_nxt = 8'(WARMUP);
                        state_nxt = (WARMUP == 0) ? ST_RUN : ST_WARM;
                    end else begin
                        wc_nxt = wc + 1'b1;
                    end
                end
            end
            ST_WARM: begin
                do_adv   = 1'b1;
                wcnt_nxt = wcnt - 8'd1;
                if (wcnt <= 8'd1) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                do_adv = bus.out_ready;
            end
            default: state_nxt = ST_SEED;
        endcase

        if (do_adv) begin
            for (int k = 0; k < K; k++) begin
                lanes_nxt[k*64 +: 64] = lfsr_adv(lanes[k*64 +: 64]);
            end
        end

        // reseed wins over any state transition but not over a same-cycle RUN handshake
        if (bus.reseed) begin
            state_nxt = ST_SEED;
            wc_nxt    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (syn_rst) begin
            state <= ST_SEED;
            wc    <= '0;
            wcnt  <= '0;
            lanes <= '0;
        end else begin
            state <= state_nxt;
            wc    <= wc_nxt;
            wcnt  <= wcnt_nxt;
            lanes <= lanes_nxt;
        end
    end

    assign bus.out_rnd    = lanes[RND_W-1:0];
    assign bus.out_valid  = (state == ST_RUN);
    assign bus.seed_ready = (state == ST_SEED);
    assign bus.busy       = (state != ST_RUN);
endmodule

// File: tb/tb_mskrnd_lfsr_feed.sv
// tb/tb_mskrnd_lfsr_feed.sv - directed self-checking bench for mskrnd_lfsr_feed
// DUT a: 32 gadgets, no warm-up (K=1). DUT b: 40 gadgets, warm-up 4 (RND_W=80, K=2).
module tb_mskrnd_lfsr_feed;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    mskrnd_lfsr_feed_if #(.RND_W(64)) ifa ();
    mskrnd_lfsr_feed_if #(.RND_W(80)) ifb ();

    mskrnd_lfsr_feed #(.d(2), .N_GADGETS(32), .WARMUP(0)) u_a (
        .clk(clk), .syn_rst(rst_a), .bus(ifa)
    );
    mskrnd_lfsr_feed #(.d(2), .N_GADGETS(40), .WARMUP(4)) u_b (
        .clk(clk), .syn_rst(rst_b), .bus(ifb)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] m_adv(input logic [63:0] s);
        logic [63:0] v;
        logic        fb;
        v = s;
        repeat (64) begin
            fb = v[0];
            v  = {1'b0, v[63:1]};
            if (fb) v = v ^ {8'hD8, 56'h0};
        end
        return v;
    endfunction

    function automatic logic [63:0] m_adv4(input logic [63:0] s);
        return m_adv(m_adv(m_adv(m_adv(s))));
    endfunction

    task automatic b_seed_pair(input logic [63:0] w0, input logic [63:0] w1, output int lat);
        ifb.seed_valid = 1'b1;
        ifb.seed_in    = w0;
        tick();
        ifb.seed_in    = w1;
        tick();
        ifb.seed_valid = 1'b0;
        lat = 1;
        while (!ifb.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    localparam logic [63:0] SA = 64'h0123456789ABCDEF;
    localparam logic [63:0] SB = 64'hFEDCBA9876543210;
    localparam logic [63:0] SC = 64'h0F1E2D3C4B5A6978;
    localparam logic [63:0] SD = 64'h8796A5B4C3D2E1F0;
    localparam logic [63:0] SS = 64'hCAFEF00D12345678;

    initial begin
        logic [63:0] ma;
        logic [63:0] mb0, mb1;
        logic [3:0]  pat;
        int          n;

        ifa.seed_in = '0; ifa.seed_valid = 0; ifa.reseed = 0; ifa.out_ready = 0;
        ifb.seed_in = '0; ifb.seed_valid = 0; ifb.reseed = 0; ifb.out_ready = 0;
        rst_a = 1; rst_b = 1;
        tick(); tick();
        rst_a = 0; rst_b = 0;

        check("a_rst_valid", ifa.out_valid, 0);
        check("a_rst_busy", ifa.busy, 1);
        check("a_rst_ready", ifa.seed_ready, 1);
        check("a_rst_rnd", ifa.out_rnd, 0);
        check("b_rst_rnd", ifb.out_rnd, 0);

        // seed 1, no warm-up
        ifa.seed_in = 64'd1; ifa.seed_valid = 1;
        tick();
        ifa.seed_valid = 0;
        n = 1;
        while (!ifa.out_valid && n < 20) begin tick(); n++; end
        check("a_latency", n, 1);
        check("a_first", ifa.out_rnd, 64'd1);
        check("a_busy_run", ifa.busy, 0);

        ma = 64'd1;
        ifa.out_ready = 1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            ma = m_adv(ma);
            if (i == 0) check("a_adv1_const", ifa.out_rnd, 64'hF500000000000001);
            check("a_stream", ifa.out_rnd, ma);
        end

        // ready toggling 1,0,0,1
        pat = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            ifa.out_ready = pat[i];
            tick();
            if (pat[i]) ma = m_adv(ma);
            check("a_toggle", ifa.out_rnd, ma);
        end
        ifa.out_ready = 0;

        // reseed together with a handshake: the handshake still advances
        ifa.out_ready = 1; ifa.reseed = 1;
        tick();
        ifa.out_ready = 0; ifa.reseed = 0;
        ma = m_adv(ma);
        check("a_rsd_valid", ifa.out_valid, 0);
        check("a_rsd_ready", ifa.seed_ready, 1);
        check("a_rsd_lanes", ifa.out_rnd, ma);

        // seed word coinciding with reseed is dropped
        ifa.seed_in = 64'hDEAD; ifa.seed_valid = 1; ifa.reseed = 1;
        tick();
        ifa.seed_valid = 0; ifa.reseed = 0;
        check("a_drop_valid", ifa.out_valid, 0);
        check("a_drop_lanes", ifa.out_rnd, ma);

        ifa.seed_in = SS; ifa.seed_valid = 1;
        tick();
        ifa.seed_valid = 0;
        check("a_new_valid", ifa.out_valid, 1);
        check("a_new_first", ifa.out_rnd, SS);
        ma = SS;
        ifa.out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            ma = m_adv(ma);
            check("a_new_stream", ifa.out_rnd, ma);
        end
        ifa.out_ready = 0;

        // zero seed
        ifa.reseed = 1;
        tick();
        ifa.reseed = 0;
        ifa.seed_in = 64'd0; ifa.seed_valid = 1;
        tick();
        ifa.seed_valid = 0;
`ifdef MSKRND_ZERO_GUARD_EN
        ma = 64'd1;
`else
        ma = 64'd0;
`endif
        check("a_zero_first", ifa.out_rnd, ma);
        ifa.out_ready = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            ma = m_adv(ma);
            check("a_zero_stream", ifa.out_rnd, ma);
        end
        ifa.out_ready = 0;

        // two lanes with warm-up 4
        b_seed_pair(SA, SB, n);
        check("b_latency", n, 5);
        mb0 = m_adv4(SA);
        mb1 = m_adv4(SB);
        check("b_first", ifb.out_rnd, {mb1[15:0], mb0});
        ifb.out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            mb0 = m_adv(mb0);
            mb1 = m_adv(mb1);
            check("b_stream", ifb.out_rnd, {mb1[15:0], mb0});
        end
        ifb.out_ready = 0;

        // reset mid-WARM
        ifb.reseed = 1;
        tick();
        ifb.reseed = 0;
        ifb.seed_valid = 1; ifb.seed_in = SC;
        tick();
        ifb.seed_in = SD;
        tick();
        ifb.seed_valid = 0;
        tick();
        check("b_in_warm", ifb.busy, 1);
        rst_b = 1;
        tick();
        rst_b = 0;
        check("b_rstw_rnd", ifb.out_rnd, 0);
        check("b_rstw_valid", ifb.out_valid, 0);
        check("b_rstw_ready", ifb.seed_ready, 1);

        // reset mid-SEED after one of two words
        ifb.seed_valid = 1; ifb.seed_in = SA;
        tick();
        ifb.seed_valid = 0;
        rst_b = 1;
        tick();
        rst_b = 0;
        check("b_rsts_rnd", ifb.out_rnd, 0);
        check("b_rsts_valid", ifb.out_valid, 0);
        check("b_rsts_ready", ifb.seed_ready, 1);

        b_seed_pair(SC, SD, n);
        check("b_re_latency", n, 5);
        mb0 = m_adv4(SC);
        mb1 = m_adv4(SD);
        check("b_re_first", ifb.out_rnd, {mb1[15:0], mb0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end
endmodule
